// File: rtl/div_arbiter_if.sv
// ============================================================================
// Module   : div_arbiter_if
// Purpose  : Client request/response and divider-core handshake bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface div_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_q;
    logic [31:0]        rsp_r;
    logic               rsp_err;
    logic               div_start;
    logic [31:0]        div_a;
    logic [31:0]        div_b;
    logic [31:0]        div_q;
    logic [31:0]        div_r;
    logic               div_ok;

    modport master (
        input  req_valid, req_a, req_b, rsp_ready, div_q, div_r, div_ok,
        output req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err,
               div_start, div_a, div_b
    );

    modport slave (
        output req_valid, req_a, req_b, rsp_ready, div_q, div_r, div_ok,
        input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err,
               div_start, div_a, div_b
    );
endinterface

`default_nettype wire

// File: rtl/div_arbiter.sv
// ============================================================================
// Module   : div_arbiter
// Purpose  : Round-robin sharing of one iterative 32-bit divider core.
//            Optional DIVARB_DIVZERO_BYPASS_EN answers B == 0 without the core.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  wire logic   clk,
    input  wire logic   reset,
    div_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  last_grant_q, last_grant_d;
    logic [IDW-1:0]  op_id_q, op_id_d;
    logic [31:0]     op_a_q, op_a_d;
    logic [31:0]     op_b_q, op_b_d;
    logic [31:0]     quo_q, quo_d;
    logic [31:0]     rem_q, rem_d;
    logic            err_q, err_d;

    logic [31:0]     req_a_w [NREQ];
    logic [31:0]     req_b_w [NREQ];
    logic            gnt_found_w;
    logic [IDW-1:0]  gnt_idx_w;
    logic [IDW:0]    cand_w;
    logic [NREQ-1:0] req_ready_w;
    logic            div_start_w;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_a_w[gi] = bus.req_a[32*gi +: 32];
            assign req_b_w[gi] = bus.req_b[32*gi +: 32];
        end
    endgenerate

    // First valid requester after last_grant, wrapping past NREQ-1 to 0.
    always_comb begin
        gnt_found_w = 1'b0;
        gnt_idx_w   = '0;
        cand_w      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_w = {1'b0, last_grant_q} + (IDW+1)'(k);
            if (cand_w >= (IDW+1)'(NREQ)) begin
                cand_w = cand_w - (IDW+1)'(NREQ);
            end
            if (!gnt_found_w && bus.req_valid[cand_w[IDW-1:0]]) begin
                gnt_found_w = 1'b1;
                gnt_idx_w   = cand_w[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_id_d      = op_id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
        err_d        = err_q;
        req_ready_w  = '0;
        div_start_w  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Gated by reset so req_ready reads 0 while reset is held.
                if (gnt_found_w && !reset) begin
                    req_ready_w[gnt_idx_w] = 1'b1;
                    last_grant_d = gnt_idx_w;
                    op_id_d      = gnt_idx_w;
                    op_a_d       = req_a_w[gnt_idx_w];
                    op_b_d       = req_b_w[gnt_idx_w];
`ifdef DIVARB_DIVZERO_BYPASS_EN
                    if (req_b_w[gnt_idx_w] == 32'd0) begin
                        quo_d   = 32'hFFFF_FFFF;
                        rem_d   = req_a_w[gnt_idx_w];
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_LOAD;
                    end
`else
                    state_d = S_LOAD;
`endif
                end
            end
            S_LOAD: begin
                div_start_w = 1'b1;
                state_d     = S_RUN;
            end
            S_RUN: begin
                // Dropping start as soon as ok rises keeps the core from reloading.
                div_start_w = !bus.div_ok;
                if (bus.div_ok) begin
                    quo_d   = bus.div_q;
                    rem_d   = bus.div_r;
                    err_d   = (op_b_q == 32'd0);
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= IDW'(NREQ-1);
            op_id_q      <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_id_q      <= op_id_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            quo_q        <= quo_d;
            rem_q        <= rem_d;
            err_q        <= err_d;
        end
    end

    assign bus.req_ready = req_ready_w;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_id    = op_id_q;
    assign bus.rsp_q     = quo_q;
    assign bus.rsp_r     = rem_q;
    assign bus.rsp_err   = err_q;
    assign bus.div_start = div_start_w;
    assign bus.div_a     = op_a_q;
    assign bus.div_b     = op_b_q;

endmodule

`default_nettype wire

// File: tb/tb_div_arbiter.sv
// ============================================================================
// Module   : tb_div_arbiter
// Purpose  : Directed bench for div_arbiter with a behavioural divider core.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_div_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
`ifdef DIVARB_DIVZERO_BYPASS_EN
    localparam int DZ_LAT = 0;
`else
    localparam int DZ_LAT = 34;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    div_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    div_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural core: busy for 32 edges after the load edge.
    logic        core_ok;
    logic [5:0]  core_cnt;
    logic [31:0] core_q, core_r;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            core_ok  <= 1'b1;
            core_cnt <= '0;
            core_q   <= '0;
            core_r   <= '0;
        end else if (core_ok && bus.div_start) begin
            core_ok  <= 1'b0;
            core_cnt <= 6'd32;
            core_q   <= (bus.div_b == 0) ? 32'hFFFF_FFFF : bus.div_a / bus.div_b;
            core_r   <= (bus.div_b == 0) ? bus.div_a : bus.div_a % bus.div_b;
        end else if (!core_ok) begin
            if (core_cnt == 6'd1) core_ok <= 1'b1;
            else                  core_cnt <= core_cnt - 6'd1;
        end
    end
    assign bus.div_ok = core_ok;
    assign bus.div_q  = core_q;
    assign bus.div_r  = core_r;

    logic start_drop = 1'b0;
    always @(negedge clk) begin
        if (!reset && !bus.div_ok && !bus.div_start) start_drop = 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid[i]       = v;
        bus.req_a[32*i +: 32]  = a;
        bus.req_b[32*i +: 32]  = b;
    endtask

    // Starts just after the accept edge; counts edges until rsp_valid is seen.
    task automatic wait_rsp(output int lat, output logic st_load, output logic st_cap);
        logic done;
        lat = 0; st_load = 1'b0; st_cap = 1'bx; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (lat == 0)  st_load = bus.div_start;
            if (lat == 33) st_cap  = bus.div_start;
            if (bus.rsp_valid || lat >= 200) begin
                done = 1'b1;
            end else begin
                @(posedge clk);
                lat++;
            end
        end
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    int          lat;
    logic        st_load, st_cap;
    logic [31:0] hq, hr;
    logic [1:0]  hid;
    logic        seen;

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        set_req(0, 1'b1, 32'd5, 32'd1);
        #1;
        chk("rst_req_ready", {60'd0, bus.req_ready}, 64'd0);
        chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rst_rsp_err",   {63'd0, bus.rsp_err},   64'd0);
        chk("rst_div_start", {63'd0, bus.div_start}, 64'd0);
        chk("rst_rsp_fields", {30'd0, bus.rsp_id, bus.rsp_q}, 64'd0);
        chk("rst_rsp_r",     {32'd0, bus.rsp_r},     64'd0);
        chk("rst_div_ab",    {bus.div_a, bus.div_b}, 64'd0);
        set_req(0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single request: 100 / 7
        set_req(0, 1'b1, 32'd100, 32'd7);
        #1 chk("single_grant", {60'd0, bus.req_ready}, 64'h1);
        @(posedge clk);
        #1 set_req(0, 1'b0, 32'd0, 32'd0);
        wait_rsp(lat, st_load, st_cap);
        chk("single_latency", 64'(lat), 64'd34);
        chk("single_start_load", {63'd0, st_load}, 64'd1);
        chk("single_start_capture", {63'd0, st_cap}, 64'd0);
        chk("single_q",   {32'd0, bus.rsp_q}, 64'd14);
        chk("single_r",   {32'd0, bus.rsp_r}, 64'd2);
        chk("single_id",  {62'd0, bus.rsp_id}, 64'd0);
        chk("single_err", {63'd0, bus.rsp_err}, 64'd0);
        handshake();

        // Fresh reset so round robin starts at requester 0
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Contention: all valid, A = 1000+i, B = 10
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 32'd1000 + 32'(i), 32'd10);
        for (int n = 0; n < 5; n++) begin
            #1 chk($sformatf("cont_grant%0d", n), {60'd0, bus.req_ready}, 64'(1 << (n % 4)));
            @(posedge clk);
            wait_rsp(lat, st_load, st_cap);
            chk($sformatf("cont_lat%0d", n), 64'(lat), 64'd34);
            chk($sformatf("cont_id%0d", n), {62'd0, bus.rsp_id}, 64'(n % 4));
            chk($sformatf("cont_q%0d", n), {32'd0, bus.rsp_q}, 64'd100);
            chk($sformatf("cont_r%0d", n), {32'd0, bus.rsp_r}, 64'(n % 4));
            chk($sformatf("cont_resp_ready%0d", n), {60'd0, bus.req_ready}, 64'd0);
            handshake();
        end
        bus.req_valid = '0;

        // Divide by zero from requester 2
        set_req(2, 1'b1, 32'h1234, 32'd0);
        #1 chk("dz_grant", {60'd0, bus.req_ready}, 64'h4);
        @(posedge clk);
        #1 set_req(2, 1'b0, 32'd0, 32'd0);
        wait_rsp(lat, st_load, st_cap);
        chk("dz_latency", 64'(lat), 64'(DZ_LAT));
        chk("dz_q",   {32'd0, bus.rsp_q}, 64'hFFFF_FFFF);
        chk("dz_r",   {32'd0, bus.rsp_r}, 64'h1234);
        chk("dz_err", {63'd0, bus.rsp_err}, 64'd1);
        chk("dz_id",  {62'd0, bus.rsp_id}, 64'd2);
        handshake();

        // Backpressure: requester 1, 50 / 6; requester 3 waits meanwhile
        set_req(1, 1'b1, 32'd50, 32'd6);
        #1 chk("bp_grant", {60'd0, bus.req_ready}, 64'h2);
        @(posedge clk);
        #1 set_req(1, 1'b0, 32'd0, 32'd0);
        wait_rsp(lat, st_load, st_cap);
        chk("bp_q", {32'd0, bus.rsp_q}, 64'd8);
        chk("bp_r", {32'd0, bus.rsp_r}, 64'd2);
        set_req(3, 1'b1, 32'd9, 32'd4);
        hq = 32'd8; hr = 32'd2; hid = 2'd1;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("bp_hold_ready", {60'd0, bus.req_ready}, 64'd0);
            chk("bp_hold_fields", {bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.rsp_q, bus.rsp_r},
                {1'b1, 1'b0, hid, hq, hr});
            @(negedge clk);
        end
        handshake();
        #1 chk("bp_resume_grant", {60'd0, bus.req_ready}, 64'h8);
        @(posedge clk);
        #1 set_req(3, 1'b0, 32'd0, 32'd0);
        wait_rsp(lat, st_load, st_cap);
        chk("bp2_lat", 64'(lat), 64'd34);
        chk("bp2_qr",  {bus.rsp_q, bus.rsp_r}, {32'd2, 32'd1});
        chk("bp2_id",  {62'd0, bus.rsp_id}, 64'd3);
        handshake();

        // Reset 15 cycles into an operation
        set_req(0, 1'b1, 32'd77, 32'd5);
        #1 chk("mid_grant", {60'd0, bus.req_ready}, 64'h1);
        @(posedge clk);
        #1 set_req(0, 1'b0, 32'd0, 32'd0);
        repeat (15) @(posedge clk);
        #2 reset = 1'b1;
        set_req(1, 1'b1, 32'd4, 32'd2);
        #1;
        chk("mid_div_start", {63'd0, bus.div_start}, 64'd0);
        chk("mid_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("mid_req_ready", {60'd0, bus.req_ready}, 64'd0);
        chk("mid_div_a",     {32'd0, bus.div_a}, 64'd0);
        set_req(1, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        chk("mid_no_response", {63'd0, seen}, 64'd0);

        set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd3);
        #1 chk("post_grant", {60'd0, bus.req_ready}, 64'h1);
        @(posedge clk);
        #1 set_req(0, 1'b0, 32'd0, 32'd0);
        wait_rsp(lat, st_load, st_cap);
        chk("post_lat", 64'(lat), 64'd34);
        chk("post_q", {32'd0, bus.rsp_q}, 64'h5555_5555);
        chk("post_r", {32'd0, bus.rsp_r}, 64'd0);
        chk("post_id_err", {61'd0, bus.rsp_id, bus.rsp_err}, 64'd0);
        handshake();

        chk("start_held_while_busy", {63'd0, start_drop}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
